can_rx_ahb: RTL and testbench
=============================

# can_rx_ahb

AHB slave register block for the CAN receive path, the counterpart of the transmit register/DMA block. Frames decoded by the CAN receiver are pushed into a small frame FIFO. The CPU pops them through memory-mapped registers at 0xf000_ff20–0xf000_ff34. A level interrupt flags pending frames.

## Interface
- DEPTH, 4: FIFO depth in frames; power of two, 2–16.
- HCLK  in  1  bus clock; all logic is on the rising edge.
- HRESET  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address; only bits [7:0] are decoded when HSEL=1.
- HWRITE  in  1  1 = write, 0 = read.
- HTRANS  in  2  transfer type; NONSEQ(2) and SEQ(3) are valid, IDLE and BUSY are ignored.
- HSIZE  in  3  ignored; every access is treated as 32-bit.
- HBURST  in  3  ignored.
- HWDATA  in  32  write data, sampled in the data phase.
- HREADY  out  1  tied to 1 (zero wait states).
- HRESP  out  2  tied to 0 (OKAY).
- HRDATA  out  32  read data.
- rxValid  in  1  one-cycle pulse: a frame is complete.
- rxdata  in  64  payload, {DH,DL}; valid with rxValid.
- rxid  in  29  identifier; valid with rxValid.
- rxdatalen  in  4  DLC; valid with rxValid.
- rxformat  in  1  0 = standard, 1 = extended.
- rxframeType  in  2  frame type.
- irq  out  1  level interrupt.

## Operation
- The FIFO holds DEPTH entries of 100 bits each: {rxframeType, rxformat, rxdatalen, rxid, rxdata}.
- Write pointer, read pointer and count are registers.
- Pointer width is log2(DEPTH). Pointers wrap modulo DEPTH.
- Count width is log2(DEPTH)+1.
- Push: rxValid=1 and count<DEPTH. The entry is written at wptr, then wptr and count increment.
- rxValid=1 while full: the frame is dropped and OVF is set (sticky).
- Pop: the data phase of a write to RX_POP (0x34) with count>0. HWDATA value is ignored. rptr increments and count decrements.
- Pop while empty: no effect.
- Push and pop in the same cycle: both take effect and count is unchanged. When full, the pop takes effect first, so the push is accepted.
- Register map (offset from 0xf000_ff00):
  - 0x20 RX_DL (RO): head rxdata[31:0].
  - 0x24 RX_DH (RO): head rxdata[63:32].
  - 0x28 RX_CMD (RO): {24'b0, format[7], frameType[6:5], 1'b0, datalen[3:0]}.
  - 0x2C RX_ID (RO): {rxid, 3'b0}. This layout matches the transmit ID register.
  - 0x30 RX_STAT: [4:0] count, [8] empty, [9] full, [16] OVF, [24] IE. Writing 1 to bit16 clears OVF. Writing bit24 sets IE.
  - 0x34 RX_POP (WO): reads return 0.
- Reads of head registers while empty return 0. Unmapped offsets read 0 and ignore writes.
- irq = IE & (count != 0 | OVF).

## Timing
- Address phase: HSEL=1, HTRANS[1]=1 (HREADY is always 1). HADDR[7:0] and HWRITE are registered as the pending data phase.
- Reads: HRDATA is registered on the edge that ends the address phase, so it is valid for the whole data phase.
- Read-after-pop in back-to-back transfers:
  - A read address phase overlaps the preceding pop's data phase.
  - That read returns the new head, i.e. the post-pop, post-push state.
  - HRDATA is computed from next-state FIFO values.
- Writes: HWDATA is applied on the edge that ends the data phase. Pop, OVF clear and IE update are visible to the following cycle.
- Push latency: a frame presented on rxValid at edge n is readable by an address phase at edge n+1 or later. RX_STAT count updates at edge n.
- An OVF set and an OVF clear in the same cycle: set wins.
- Reset (async, HRESET=0) forces:
  - rptr, wptr, count = 0.
  - OVF = 0, IE = 0.
  - HRDATA = 0, irq = 0.
  - Data-phase valid = 0.
- FIFO storage is not reset.
- Reset mid-transfer aborts the transfer with no pop.
- The first transfer is accepted on the first edge after reset is released.

## Test plan
- Single frame: rxValid with rxdata=64'h1122334455667788, rxid=29'h123, datalen=8, format=1, type=0, IE=1. Required:
  - irq=1.
  - Reads: DL=55667788, DH=11223344, CMD=0000_0088, ID=0000_0918, STAT count=1.
  - Pop → STAT=0000_0100 (empty) and irq=0.
- Fill and overflow: DEPTH+1 frames with rxdata=k. Required:
  - STAT count=4, full=1, OVF=1.
  - Pops return rxdata 0..3; frame 4 is lost.
  - Write 0x0001_0000 to STAT clears OVF.
- Wrap-around: 3 pushes, 3 pops, 3 pushes. Required: the heads read back in push order and count=3.
- Simultaneous push and pop while full: count stays 4, OVF stays 0, and the new frame appears after 3 further pops.
- Back-to-back write to RX_POP followed by a read of RX_DL: the read returns the second frame's DL.
- Async reset asserted between an address phase and its data phase: no pop occurs, all outputs are 0 immediately, and STAT reads 0000_0100 after release.

Source files
------------

// File: rtl/can_rx_ahb.sv
// CAN receive register block: AHB slave with a DEPTH-frame receive FIFO,
// head-of-queue registers, pop register, status/overflow and a level interrupt.
module can_rx_ahb #(
  parameter int DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA,
  input  logic        rxValid,
  input  logic [63:0] rxdata,
  input  logic [28:0] rxid,
  input  logic [3:0]  rxdatalen,
  input  logic        rxformat,
  input  logic [1:0]  rxframeType,
  output logic        irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 100;

  localparam logic [7:0] ADDR_DL   = 8'h20;
  localparam logic [7:0] ADDR_DH   = 8'h24;
  localparam logic [7:0] ADDR_CMD  = 8'h28;
  localparam logic [7:0] ADDR_ID   = 8'h2C;
  localparam logic [7:0] ADDR_STAT = 8'h30;
  localparam logic [7:0] ADDR_POP  = 8'h34;

  logic [EW-1:0] mem [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          ie_q, ie_d;
  logic          dp_valid_q;
  logic          dp_write_q;
  logic [7:0]    dp_addr_q;
  logic [31:0]   hrdata_q, rd_data;

  logic          addr_phase;
  logic          dp_wr;
  logic          full_q;
  logic          push;
  logic          pop;
  logic          stat_wr;
  logic          bypass;
  logic          head_ok;
  logic [EW-1:0] new_entry;
  logic [EW-1:0] head;

  wire unused_ok = ^{HSIZE, HBURST, HADDR[31:8], HTRANS[0],
                     HWDATA[31:25], HWDATA[23:17], HWDATA[15:0]};

  assign HREADY = 1'b1;
  assign HRESP  = 2'b00;
  assign HRDATA = hrdata_q;

  assign addr_phase = HSEL & HTRANS[1];
  assign dp_wr      = dp_valid_q & dp_write_q;
  assign full_q     = (count_q == CW'(DEPTH));
  assign pop        = dp_wr && (dp_addr_q == ADDR_POP) && (count_q != '0);
  // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
  assign push       = rxValid && (!full_q || pop);
  assign stat_wr    = dp_wr && (dp_addr_q == ADDR_STAT);
  assign new_entry  = {rxframeType, rxformat, rxdatalen, rxid, rxdata};

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    ie_d    = ie_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (stat_wr && HWDATA[16]) ovf_d = 1'b0;
    if (rxValid && !push)      ovf_d = 1'b1;
    if (stat_wr)               ie_d  = HWDATA[24];
  end

  // Read data reflects the post-pop, post-push state; a frame pushed into an
  // (effectively) empty FIFO this cycle is forwarded straight to the head.
  assign bypass  = push && (count_q == (pop ? CW'(1) : CW'(0)));
  assign head    = bypass ? new_entry : mem[rptr_d];
  assign head_ok = (count_d != '0);

  always_comb begin
    rd_data = '0;
    case (HADDR[7:0])
      ADDR_DL:   if (head_ok) rd_data = head[31:0];
      ADDR_DH:   if (head_ok) rd_data = head[63:32];
      ADDR_CMD:  if (head_ok) rd_data = {24'b0, head[97], head[99:98], 1'b0, head[96:93]};
      ADDR_ID:   if (head_ok) rd_data = {head[92:64], 3'b0};
      ADDR_STAT: begin
        rd_data[4:0] = 5'(count_d);
        rd_data[8]   = (count_d == '0);
        rd_data[9]   = (count_d == CW'(DEPTH));
        rd_data[16]  = ovf_d;
        rd_data[24]  = ie_d;
      end
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (push) mem[wptr_q] <= new_entry;
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      ie_q       <= 1'b0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      hrdata_q   <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      ie_q       <= ie_d;
      dp_valid_q <= addr_phase;
      dp_write_q <= HWRITE;
      dp_addr_q  <= HADDR[7:0];
      hrdata_q   <= (addr_phase && !HWRITE) ? rd_data : 32'h0;
    end
  end

  assign irq = ie_q & ((count_q != '0) | ovf_q);

endmodule

// File: tb/tb_can_rx_ahb.sv
// Directed testbench for can_rx_ahb: register reads, pops, overflow, wrap,
// full push/pop, back-to-back pop/read and reset during a transfer.
module tb_can_rx_ahb;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic        rxValid;
  logic [63:0] rxdata;
  logic [28:0] rxid;
  logic [3:0]  rxdatalen;
  logic        rxformat;
  logic [1:0]  rxframeType;
  logic        irq;

  int checks = 0;
  int errors = 0;

  can_rx_ahb #(.DEPTH(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .rxValid(rxValid), .rxdata(rxdata), .rxid(rxid), .rxdatalen(rxdatalen),
    .rxformat(rxformat), .rxframeType(rxframeType), .irq(irq)
  );

  always #5 HCLK = ~HCLK;

  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'd2; HWRITE = 1'b1; HADDR = 32'hf000_ff00 | 32'(a);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'd0; HWRITE = 1'b0; HWDATA = d;
    @(posedge HCLK); #1;
    $display("write addr=%02h data=%08h", a, d);
  endtask

  task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'd2; HWRITE = 1'b0; HADDR = 32'hf000_ff00 | 32'(a);
    @(posedge HCLK); #1;
    d = HRDATA;
    HSEL = 1'b0; HTRANS = 2'd0;
    $display("read  addr=%02h data=%08h", a, d);
  endtask

  task automatic push(input logic [63:0] d, input logic [28:0] id, input logic [3:0] len,
                      input logic fmt, input logic [1:0] ft);
    rxValid = 1'b1; rxdata = d; rxid = id; rxdatalen = len; rxformat = fmt; rxframeType = ft;
    @(posedge HCLK); #1;
    rxValid = 1'b0;
    $display("push  data=%016h id=%08h", d, id);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    HRESET = 1'b0; HSEL = 0; HADDR = 0; HWRITE = 0; HTRANS = 0; HSIZE = 3'd2; HBURST = 0;
    HWDATA = 0; rxValid = 0; rxdata = 0; rxid = 0; rxdatalen = 0; rxformat = 0; rxframeType = 0;
    #13;
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata got=%08h exp=00000000", HRDATA); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL reset_hready got=%b exp=1", HREADY); end
    checks++; if (HRESP !== 2'b00) begin errors++; $display("FAIL reset_hresp got=%b exp=00", HRESP); end
    @(negedge HCLK); HRESET = 1'b1;
    @(posedge HCLK); #1;
    ahb_read(8'h30, r);
    checks++; if (r !== 32'h0000_0100) begin errors++; $display("FAIL reset_stat got=%08h exp=00000100", r); end
  endtask

  task automatic test_single_frame;
    logic [31:0] r;
    ahb_write(8'h30, 32'h0100_0000);
    push(64'h1122334455667788, 29'h123, 4'd8, 1'b1, 2'd0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL single_irq got=%b exp=1", irq); end
    ahb_read(8'h20, r);
    checks++; if (r !== 32'h5566_7788) begin errors++; $display("FAIL single_dl got=%08h exp=55667788", r); end
    ahb_read(8'h24, r);
    checks++; if (r !== 32'h1122_3344) begin errors++; $display("FAIL single_dh got=%08h exp=11223344", r); end
    ahb_read(8'h28, r);
    checks++; if (r !== 32'h0000_0088) begin errors++; $display("FAIL single_cmd got=%08h exp=00000088", r); end
    ahb_read(8'h2C, r);
    checks++; if (r !== 32'h0000_0918) begin errors++; $display("FAIL single_id got=%08h exp=00000918", r); end
    ahb_read(8'h30, r);
    checks++; if (r !== 32'h0100_0001) begin errors++; $display("FAIL single_stat got=%08h exp=01000001", r); end
    ahb_read(8'h34, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL single_pop_read got=%08h exp=00000000", r); end
    ahb_write(8'h34, 32'hFFFF_FFFF);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_after_pop got=%b exp=0", irq); end
    ahb_read(8'h30, r);
    checks++; if ((r & 32'h00FF_FFFF) !== 32'h0000_0100) begin errors++; $display("FAIL single_stat_empty got=%08h exp=00000100", r & 32'h00FF_FFFF); end
    ahb_read(8'h20, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL single_dl_empty got=%08h exp=00000000", r); end
    ahb_write(8'h34, 32'h0);
    ahb_read(8'h30, r);
    checks++; if ((r & 32'h00FF_FFFF) !== 32'h0000_0100) begin errors++; $display("FAIL pop_empty_stat got=%08h exp=00000100", r & 32'h00FF_FFFF); end
  endtask

  task automatic test_fill_overflow;
    logic [31:0] r;
    for (int k = 0; k < 5; k++) push(64'(k), 29'(16 + k), 4'd1, 1'b0, 2'd1);
    ahb_read(8'h30, r);
    checks++; if ((r & 32'h00FF_FFFF) !== 32'h0001_0204) begin errors++; $display("FAIL ovf_stat got=%08h exp=00010204", r & 32'h00FF_FFFF); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ovf_irq got=%b exp=1", irq); end
    for (int k = 0; k < 4; k++) begin
      ahb_read(8'h20, r);
      checks++; if (r !== 32'(k)) begin errors++; $display("FAIL ovf_pop_dl[%0d] got=%08h exp=%08h", k, r, 32'(k)); end
      ahb_write(8'h34, 32'h0);
    end
    ahb_read(8'h30, r);
    checks++; if ((r & 32'h00FF_FFFF) !== 32'h0001_0100) begin errors++; $display("FAIL ovf_sticky got=%08h exp=00010100", r & 32'h00FF_FFFF); end
    ahb_write(8'h30, 32'h0001_0000);
    ahb_read(8'h30, r);
    checks++; if ((r & 32'h00FF_FFFF) !== 32'h0000_0100) begin errors++; $display("FAIL ovf_clear got=%08h exp=00000100", r & 32'h00FF_FFFF); end
    ahb_write(8'h30, 32'h0100_0000);
  endtask

  task automatic test_wrap;
    logic [31:0] r;
    for (int k = 0; k < 3; k++) push(64'(32'hA0 + k), 29'h1, 4'd2, 1'b0, 2'd0);
    for (int k = 0; k < 3; k++) ahb_write(8'h34, 32'h0);
    for (int k = 0; k < 3; k++) push(64'(32'hB0 + k), 29'h2, 4'd2, 1'b0, 2'd0);
    ahb_read(8'h30, r);
    checks++; if ((r & 32'h00FF_FFFF) !== 32'h0000_0003) begin errors++; $display("FAIL wrap_stat got=%08h exp=00000003", r & 32'h00FF_FFFF); end
    for (int k = 0; k < 3; k++) begin
      ahb_read(8'h20, r);
      checks++; if (r !== 32'hB0 + 32'(k)) begin errors++; $display("FAIL wrap_dl[%0d] got=%08h exp=%08h", k, r, 32'hB0 + 32'(k)); end
      ahb_write(8'h34, 32'h0);
    end
  endtask

  task automatic test_full_push_pop;
    logic [31:0] r;
    for (int k = 0; k < 4; k++) push(64'(10 + k), 29'h3, 4'd4, 1'b1, 2'd2);
    HSEL = 1'b1; HTRANS = 2'd2; HWRITE = 1'b1; HADDR = 32'hf000_ff34;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'd0; HWRITE = 1'b0; HWDATA = 32'h0;
    rxValid = 1'b1; rxdata = 64'd14;
    @(posedge HCLK); #1;
    rxValid = 1'b0;
    $display("pop+push data=%016h", 64'd14);
    ahb_read(8'h30, r);
    checks++; if ((r & 32'h00FF_FFFF) !== 32'h0000_0204) begin errors++; $display("FAIL fullpp_stat got=%08h exp=00000204", r & 32'h00FF_FFFF); end
    for (int k = 0; k < 4; k++) begin
      ahb_read(8'h20, r);
      checks++; if (r !== 32'(11 + k)) begin errors++; $display("FAIL fullpp_dl[%0d] got=%08h exp=%08h", k, r, 32'(11 + k)); end
      ahb_write(8'h34, 32'h0);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    push(64'h0000_0001_0000_0021, 29'h4, 4'd8, 1'b0, 2'd0);
    push(64'h0000_0002_0000_0022, 29'h5, 4'd8, 1'b0, 2'd0);
    HSEL = 1'b1; HTRANS = 2'd2; HWRITE = 1'b1; HADDR = 32'hf000_ff34;
    @(posedge HCLK); #1;
    HWDATA = 32'h0; HWRITE = 1'b0; HADDR = 32'hf000_ff20;
    @(posedge HCLK); #1;
    r = HRDATA;
    HSEL = 1'b0; HTRANS = 2'd0;
    $display("pop->read addr=20 data=%08h", r);
    checks++; if (r !== 32'h0000_0022) begin errors++; $display("FAIL b2b_dl got=%08h exp=00000022", r); end
    ahb_write(8'h34, 32'h0);
    ahb_read(8'h30, r);
    checks++; if ((r & 32'h00FF_FFFF) !== 32'h0000_0100) begin errors++; $display("FAIL b2b_stat got=%08h exp=00000100", r & 32'h00FF_FFFF); end
  endtask

  task automatic test_async_reset;
    logic [31:0] r;
    push(64'h55, 29'h6, 4'd1, 1'b0, 2'd0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL arst_irq_before got=%b exp=1", irq); end
    HSEL = 1'b1; HTRANS = 2'd2; HWRITE = 1'b1; HADDR = 32'hf000_ff34;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'd0; HWRITE = 1'b0; HWDATA = 32'h0;
    #2 HRESET = 1'b0;
    #1;
    $display("async reset asserted in data phase");
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL arst_irq got=%b exp=0", irq); end
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL arst_hrdata got=%08h exp=00000000", HRDATA); end
    checks++; if (HREADY !== 1'b1 || HRESP !== 2'b00) begin errors++; $display("FAIL arst_resp got=%b/%b exp=1/00", HREADY, HRESP); end
    @(posedge HCLK);
    @(negedge HCLK); HRESET = 1'b1;
    @(posedge HCLK); #1;
    ahb_read(8'h30, r);
    checks++; if (r !== 32'h0000_0100) begin errors++; $display("FAIL arst_stat got=%08h exp=00000100", r); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_fill_overflow();
    test_wrap();
    test_full_push_pop();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
